// File: rtl/register_array_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// +------------------------------------------------------------------+
// | Package   : register_array_pkg                                   |
// | Purpose   : Shared types for the register-array priority queue:  |
// |             operation codes, slot record and FSM states.         |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
package register_array_pkg;

  // Widest key any instance may carry. Instances hold narrower keys
  // zero-extended, so unsigned ordering is unaffected.
  localparam int unsigned RA_KEY_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_ENQ     = 2'd1,
    OP_DEQ     = 2'd2,
    OP_REPLACE = 2'd3
  } ra_op_e;

  // One storage slot; an invalid slot ranks below every valid key.
  typedef struct packed {
    logic                    valid;
    logic [RA_KEY_MAX_W-1:0] key;
  } ra_slot_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } ra_state_e;

endpackage
`default_nettype wire

// File: rtl/ra_cmp_swap.sv
`default_nettype none
`timescale 1ns / 1ps
// +------------------------------------------------------------------+
// | Module    : ra_cmp_swap                                          |
// | Purpose   : Two-input compare-exchange on slot records. o_hi     |
// |             receives the better entry (largest key when          |
// |             MAX_FIRST=1, smallest otherwise; valid beats invalid)|
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module ra_cmp_swap
  import register_array_pkg::*;
#(
  parameter int MAX_FIRST = 1
) (
  input  ra_slot_t i_a,
  input  ra_slot_t i_b,
  output ra_slot_t o_hi,
  output ra_slot_t o_lo
);

  logic w_b_better;

  // Decide whether b outranks a; ties keep the original order.
  always_comb begin
    w_b_better = 1'b0;
    if (i_a.valid != i_b.valid) begin
      w_b_better = i_b.valid;
    end else if (i_a.valid) begin
      if (MAX_FIRST != 0) w_b_better = (i_b.key > i_a.key);
      else                w_b_better = (i_b.key < i_a.key);
    end
  end

  assign o_hi = w_b_better ? i_b : i_a;
  assign o_lo = w_b_better ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/register_array_pq.sv
`default_nettype none
`timescale 1ns / 1ps
// +------------------------------------------------------------------+
// | Module    : register_array_pq                                    |
// | Purpose   : Register-array priority queue. Slots are re-ordered  |
// |             every cycle by a pair / cross / head compare-exchange|
// |             network; each accepted op is followed by one SETTLE  |
// |             cycle so the head is correct whenever o_ready is high|
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module register_array_pq
  import register_array_pkg::*;
#(
  parameter int QUEUE_SIZE = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_FIRST  = 1
) (
  input  logic                              CLK,
  input  logic                              RSTn,
  input  logic                              i_op_valid,
  input  logic [1:0]                        i_op,
  input  logic [DATA_WIDTH-1:0]             i_data,
  output logic                              o_ready,
  output logic [DATA_WIDTH-1:0]             o_top_data,
  output logic                              o_top_valid,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
  output logic                              o_full,
  output logic                              o_empty,
  output logic                              o_err
);

  localparam int                c_cnt_w    = $clog2(QUEUE_SIZE + 1);
  localparam int                c_n_pair   = QUEUE_SIZE / 2;
  localparam int                c_n_cross  = (QUEUE_SIZE - 1) / 2;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(QUEUE_SIZE);

  ra_slot_t  r_slot    [QUEUE_SIZE];
  ra_slot_t  w_op_slot [QUEUE_SIZE];
  ra_slot_t  w_pair    [QUEUE_SIZE];
  ra_slot_t  w_cross   [QUEUE_SIZE];
  ra_slot_t  w_next    [QUEUE_SIZE];
  ra_slot_t  w_new_slot;
  logic      w_hole;

  ra_state_e          r_state;
  logic               r_ready;
  logic               r_err;
  logic [c_cnt_w-1:0] r_count;

  ra_op_e w_op;
  logic   w_full, w_empty, w_req;
  logic   w_do_insert, w_do_deq, w_do_repl, w_accept, w_reject;

  assign w_op    = ra_op_e'(i_op);
  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_req   = i_op_valid && r_ready;

  // REPLACE on an empty queue is treated as an insertion.
  assign w_do_insert = w_req && (((w_op == OP_ENQ) && !w_full) ||
                                 ((w_op == OP_REPLACE) && w_empty));
  assign w_do_deq    = w_req && (w_op == OP_DEQ) && !w_empty;
  assign w_do_repl   = w_req && (w_op == OP_REPLACE) && !w_empty;
  assign w_accept    = w_do_insert || w_do_deq || w_do_repl;
  assign w_reject    = w_req && (((w_op == OP_ENQ) && w_full) ||
                                 ((w_op == OP_DEQ) && w_empty));

  // Apply the accepted operation to the slot image ahead of the network.
  // Insertion shifts right only up to the first free slot, so an invalid
  // bubble still sinking after a recent DEQ is consumed instead of pushing
  // a valid entry off the end.
  always_comb begin
    w_new_slot                        = '0;
    w_new_slot.valid                  = 1'b1;
    w_new_slot.key[DATA_WIDTH-1:0]    = i_data;
    w_hole                            = 1'b0;
    for (int j = 0; j < QUEUE_SIZE; j++) w_op_slot[j] = r_slot[j];
    if (w_do_insert) begin
      w_op_slot[0] = w_new_slot;
      for (int j = 1; j < QUEUE_SIZE; j++) begin
        w_hole = w_hole || !r_slot[j-1].valid;
        if (!w_hole) w_op_slot[j] = r_slot[j-1];
      end
    end else if (w_do_deq) begin
      w_op_slot[0].valid = 1'b0;
    end else if (w_do_repl) begin
      w_op_slot[0].key = w_new_slot.key;
    end
  end

  // Pair stage: order (2i, 2i+1); an odd last slot passes through.
  for (genvar gi = 0; gi < c_n_pair; gi++) begin : g_pair
    ra_cmp_swap #(.MAX_FIRST(MAX_FIRST)) u_cs (
      .i_a (w_op_slot[2*gi]),   .i_b (w_op_slot[2*gi+1]),
      .o_hi(w_pair[2*gi]),      .o_lo(w_pair[2*gi+1])
    );
  end
  if (QUEUE_SIZE % 2 == 1) begin : g_pair_odd
    assign w_pair[QUEUE_SIZE-1] = w_op_slot[QUEUE_SIZE-1];
  end

  // Cross stage: order (2i-1, 2i); slot 0 and an even-size last slot pass.
  assign w_cross[0] = w_pair[0];
  for (genvar gi = 1; gi <= c_n_cross; gi++) begin : g_cross
    ra_cmp_swap #(.MAX_FIRST(MAX_FIRST)) u_cs (
      .i_a (w_pair[2*gi-1]),    .i_b (w_pair[2*gi]),
      .o_hi(w_cross[2*gi-1]),   .o_lo(w_cross[2*gi])
    );
  end
  if (QUEUE_SIZE % 2 == 0) begin : g_cross_even
    assign w_cross[QUEUE_SIZE-1] = w_pair[QUEUE_SIZE-1];
  end

  // Head stage: slot 0 takes the better of the re-formed pair 0.
  ra_cmp_swap #(.MAX_FIRST(MAX_FIRST)) u_head_cs (
    .i_a (w_cross[0]), .i_b (w_cross[1]),
    .o_hi(w_next[0]),  .o_lo(w_next[1])
  );
  for (genvar gi = 2; gi < QUEUE_SIZE; gi++) begin : g_tail
    assign w_next[gi] = w_cross[gi];
  end

  // Slot storage follows the network output every cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int j = 0; j < QUEUE_SIZE; j++) r_slot[j] <= '0;
    end else begin
      for (int j = 0; j < QUEUE_SIZE; j++) r_slot[j] <= w_next[j];
    end
  end

  // Entry count moves on the accepting edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)            r_count <= '0;
    else if (w_do_insert) r_count <= r_count + c_cnt_w'(1);
    else if (w_do_deq)    r_count <= r_count - c_cnt_w'(1);
  end

  // Control FSM: one SETTLE cycle after every accepted op; error pulse.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETTLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_top_valid = r_slot[0].valid;
  assign o_top_data  = r_slot[0].valid ? r_slot[0].key[DATA_WIDTH-1:0] : '0;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_register_array_pq.sv
`default_nettype none
`timescale 1ns / 1ps
// +------------------------------------------------------------------+
// | Module    : tb_register_array_pq                                 |
// | Purpose   : Scoreboard bench for register_array_pq. Three        |
// |             instances: max-first size 4, min-first size 4 and    |
// |             max-first size 5.                                    |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module tb_register_array_pq;

  localparam int DW = 16;
  localparam int CW = 3;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic          op_valid [3];
  logic [1:0]    op       [3];
  logic [DW-1:0] data     [3];
  logic          ready    [3];
  logic          top_valid[3];
  logic          full     [3];
  logic          empty    [3];
  logic          err      [3];
  logic [DW-1:0] top_data [3];
  logic [CW-1:0] cnt      [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          tv;
    logic [DW-1:0] td;
    logic [CW-1:0] cnt;
    logic          er;
  } exp_t;

  exp_t          sb[$];
  int            mq[$];
  logic          obs_err;
  logic [CW-1:0] obs_cnt;

  register_array_pq #(.QUEUE_SIZE(4), .DATA_WIDTH(DW), .MAX_FIRST(1)) u_max (
    .CLK(CLK), .RSTn(RSTn), .i_op_valid(op_valid[0]), .i_op(op[0]), .i_data(data[0]),
    .o_ready(ready[0]), .o_top_data(top_data[0]), .o_top_valid(top_valid[0]),
    .o_count(cnt[0]), .o_full(full[0]), .o_empty(empty[0]), .o_err(err[0]));

  register_array_pq #(.QUEUE_SIZE(4), .DATA_WIDTH(DW), .MAX_FIRST(0)) u_min (
    .CLK(CLK), .RSTn(RSTn), .i_op_valid(op_valid[1]), .i_op(op[1]), .i_data(data[1]),
    .o_ready(ready[1]), .o_top_data(top_data[1]), .o_top_valid(top_valid[1]),
    .o_count(cnt[1]), .o_full(full[1]), .o_empty(empty[1]), .o_err(err[1]));

  register_array_pq #(.QUEUE_SIZE(5), .DATA_WIDTH(DW), .MAX_FIRST(1)) u_odd (
    .CLK(CLK), .RSTn(RSTn), .i_op_valid(op_valid[2]), .i_op(op[2]), .i_data(data[2]),
    .o_ready(ready[2]), .o_top_data(top_data[2]), .o_top_valid(top_valid[2]),
    .o_count(cnt[2]), .o_full(full[2]), .o_empty(empty[2]), .o_err(err[2]));

  // Reference model: unordered list, best entry located by linear search.
  function automatic int best_idx(input bit maxf);
    int b = 0;
    for (int i = 1; i < mq.size(); i++)
      if (maxf ? (mq[i] > mq[b]) : (mq[i] < mq[b])) b = i;
    return b;
  endfunction

  // Apply one op to the model and push the expected post-op outputs.
  function automatic void model_push(input bit maxf, input int qs,
                                     input logic [1:0] opc, input int v);
    exp_t e;
    e.er = 1'b0;
    case (opc)
      2'd1: if (mq.size() == qs) e.er = 1'b1; else mq.push_back(v);
      2'd2: if (mq.size() == 0)  e.er = 1'b1; else mq.delete(best_idx(maxf));
      2'd3: if (mq.size() == 0)  mq.push_back(v); else mq[best_idx(maxf)] = v;
      default: ;
    endcase
    e.cnt = CW'(mq.size());
    e.tv  = (mq.size() > 0);
    e.td  = e.tv ? DW'(mq[best_idx(maxf)]) : '0;
    sb.push_back(e);
  endfunction

  // Present one op at the next edge, capture err/count just after it,
  // then wait (bounded) for o_ready.
  task automatic step(input int d, input logic [1:0] opc, input logic [DW-1:0] v);
    int guard = 0;
    op_valid[d] = 1'b1; op[d] = opc; data[d] = v;
    @(posedge CLK); #1;
    op_valid[d] = 1'b0; op[d] = 2'd0;
    obs_err = err[d];
    obs_cnt = cnt[d];
    while (ready[d] !== 1'b1 && guard < 8) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (ready[d] !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_timeout dut=%0d got=%b want=1", d, ready[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++; if (ready[d] !== 1'b1)     begin bad++; $display("FAIL rst_ready dut=%0d got=%b want=1", d, ready[d]); end
      total++; if (top_valid[d] !== 1'b0) begin bad++; $display("FAIL rst_top_valid dut=%0d got=%b want=0", d, top_valid[d]); end
      total++; if (top_data[d] !== '0)    begin bad++; $display("FAIL rst_top_data dut=%0d got=%0d want=0", d, top_data[d]); end
      total++; if (cnt[d] !== '0)         begin bad++; $display("FAIL rst_count dut=%0d got=%0d want=0", d, cnt[d]); end
      total++; if (empty[d] !== 1'b1)     begin bad++; $display("FAIL rst_empty dut=%0d got=%b want=1", d, empty[d]); end
      total++; if (full[d] !== 1'b0)      begin bad++; $display("FAIL rst_full dut=%0d got=%b want=0", d, full[d]); end
      total++; if (err[d] !== 1'b0)       begin bad++; $display("FAIL rst_err dut=%0d got=%b want=0", d, err[d]); end
    end
  endtask

  task automatic test_enq_deq();
    exp_t e;
    int   keys[3] = '{5, 9, 2};
    int   heads[3] = '{9, 5, 2};
    mq.delete();
    foreach (keys[i]) begin
      model_push(1'b1, 4, 2'd1, keys[i]);
      step(0, 2'd1, DW'(keys[i]));
      e = sb.pop_front();
      total++; if (top_data[0] !== e.td)   begin bad++; $display("FAIL enq_head got=%0d want=%0d", top_data[0], e.td); end
      total++; if (cnt[0] !== e.cnt)       begin bad++; $display("FAIL enq_count got=%0d want=%0d", cnt[0], e.cnt); end
      total++; if (top_valid[0] !== e.tv)  begin bad++; $display("FAIL enq_top_valid got=%b want=%b", top_valid[0], e.tv); end
    end
    foreach (heads[i]) begin
      total++; if (top_data[0] !== DW'(heads[i])) begin bad++; $display("FAIL deq_pop_order got=%0d want=%0d", top_data[0], heads[i]); end
      model_push(1'b1, 4, 2'd2, 0);
      step(0, 2'd2, '0);
      e = sb.pop_front();
      total++; if (top_data[0] !== e.td)  begin bad++; $display("FAIL deq_head got=%0d want=%0d", top_data[0], e.td); end
      total++; if (cnt[0] !== e.cnt)      begin bad++; $display("FAIL deq_count got=%0d want=%0d", cnt[0], e.cnt); end
      total++; if (top_valid[0] !== e.tv) begin bad++; $display("FAIL deq_top_valid got=%b want=%b", top_valid[0], e.tv); end
    end
    total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL drained_empty got=%b want=1", empty[0]); end
  endtask

  task automatic test_errors();
    exp_t e;
    mq.delete();
    for (int k = 1; k <= 5; k++) begin
      int v = (k == 5) ? 7 : k;
      model_push(1'b1, 4, 2'd1, v);
      step(0, 2'd1, DW'(v));
      e = sb.pop_front();
      total++; if (obs_err !== e.er)     begin bad++; $display("FAIL fill_err k=%0d got=%b want=%b", k, obs_err, e.er); end
      total++; if (top_data[0] !== e.td) begin bad++; $display("FAIL fill_head k=%0d got=%0d want=%0d", k, top_data[0], e.td); end
      total++; if (cnt[0] !== e.cnt)     begin bad++; $display("FAIL fill_count k=%0d got=%0d want=%0d", k, cnt[0], e.cnt); end
    end
    total++; if (full[0] !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full[0]); end
    @(posedge CLK); #1;
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", err[0]); end
    for (int k = 0; k < 5; k++) begin
      model_push(1'b1, 4, 2'd2, 0);
      step(0, 2'd2, '0);
      e = sb.pop_front();
      total++; if (obs_err !== e.er)      begin bad++; $display("FAIL drain_err k=%0d got=%b want=%b", k, obs_err, e.er); end
      total++; if (top_data[0] !== e.td)  begin bad++; $display("FAIL drain_head k=%0d got=%0d want=%0d", k, top_data[0], e.td); end
      total++; if (cnt[0] !== e.cnt)      begin bad++; $display("FAIL drain_count k=%0d got=%0d want=%0d", k, cnt[0], e.cnt); end
      total++; if (top_valid[0] !== e.tv) begin bad++; $display("FAIL drain_top_valid k=%0d got=%b want=%b", k, top_valid[0], e.tv); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mq.delete();
    model_push(1'b1, 4, 2'd1, 3);
    op_valid[0] = 1'b1; op[0] = 2'd1; data[0] = 16'd3;
    @(posedge CLK); #1;
    total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL settle_ready got=%b want=0", ready[0]); end
    op[0] = 2'd2;
    @(posedge CLK); #1;
    op_valid[0] = 1'b0; op[0] = 2'd0;
    e = sb.pop_front();
    total++; if (cnt[0] !== e.cnt)     begin bad++; $display("FAIL held_req_count got=%0d want=%0d", cnt[0], e.cnt); end
    total++; if (top_data[0] !== e.td) begin bad++; $display("FAIL held_req_head got=%0d want=%0d", top_data[0], e.td); end
    total++; if (ready[0] !== 1'b1)    begin bad++; $display("FAIL held_req_ready got=%b want=1", ready[0]); end
  endtask

  task automatic test_min_replace();
    exp_t       e;
    logic [1:0] ops[8]  = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
    int         vals[8] = '{8, 3, 6, 10, 1, 0, 0, 0};
    mq.delete();
    for (int k = 0; k < 9; k++) begin
      logic [1:0] oc = (k == 8) ? 2'd3 : ops[k];
      int         v  = (k == 8) ? 5 : vals[k];
      model_push(1'b0, 4, oc, v);
      step(1, oc, DW'(v));
      e = sb.pop_front();
      total++; if (top_data[1] !== e.td)  begin bad++; $display("FAIL min_head k=%0d got=%0d want=%0d", k, top_data[1], e.td); end
      total++; if (cnt[1] !== e.cnt)      begin bad++; $display("FAIL min_count k=%0d got=%0d want=%0d", k, cnt[1], e.cnt); end
      total++; if (top_valid[1] !== e.tv) begin bad++; $display("FAIL min_top_valid k=%0d got=%b want=%b", k, top_valid[1], e.tv); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    mq.delete();
    for (int k = 0; k < 2000; k++) begin
      logic [1:0] oc = 2'($urandom_range(0, 3));
      int         v  = int'($urandom_range(0, 31));
      model_push(1'b1, 5, oc, v);
      step(2, oc, DW'(v));
      e = sb.pop_front();
      total++; if (obs_err !== e.er)      begin bad++; $display("FAIL rnd_err k=%0d op=%0d got=%b want=%b", k, oc, obs_err, e.er); end
      total++; if (obs_cnt !== e.cnt)     begin bad++; $display("FAIL rnd_count_edge k=%0d got=%0d want=%0d", k, obs_cnt, e.cnt); end
      total++; if (top_data[2] !== e.td)  begin bad++; $display("FAIL rnd_head k=%0d op=%0d got=%0d want=%0d", k, oc, top_data[2], e.td); end
      total++; if (top_valid[2] !== e.tv) begin bad++; $display("FAIL rnd_top_valid k=%0d got=%b want=%b", k, top_valid[2], e.tv); end
      total++; if (empty[2] !== (e.cnt == 0)) begin bad++; $display("FAIL rnd_empty k=%0d got=%b want=%b", k, empty[2], e.cnt == 0); end
      total++; if (full[2] !== (e.cnt == 5))  begin bad++; $display("FAIL rnd_full k=%0d got=%b want=%b", k, full[2], e.cnt == 5); end
    end
  endtask

  task automatic test_reset_mid_settle();
    if (full[2] === 1'b1) step(2, 2'd2, '0);
    op_valid[2] = 1'b1; op[2] = 2'd1; data[2] = 16'd11;
    @(posedge CLK); #1;
    op_valid[2] = 1'b0; op[2] = 2'd0;
    total++; if (ready[2] !== 1'b0) begin bad++; $display("FAIL mid_settle_ready got=%b want=0", ready[2]); end
    RSTn = 1'b0;
    #2;
    total++; if (ready[2] !== 1'b1)     begin bad++; $display("FAIL arst_ready got=%b want=1", ready[2]); end
    total++; if (cnt[2] !== '0)         begin bad++; $display("FAIL arst_count got=%0d want=0", cnt[2]); end
    total++; if (top_valid[2] !== 1'b0) begin bad++; $display("FAIL arst_top_valid got=%b want=0", top_valid[2]); end
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    total++; if (ready[2] !== 1'b1)     begin bad++; $display("FAIL post_rst_ready got=%b want=1", ready[2]); end
    total++; if (top_valid[2] !== 1'b0) begin bad++; $display("FAIL post_rst_top_valid got=%b want=0", top_valid[2]); end
    total++; if (top_data[2] !== '0)    begin bad++; $display("FAIL post_rst_top_data got=%0d want=0", top_data[2]); end
    total++; if (cnt[2] !== '0)         begin bad++; $display("FAIL post_rst_count got=%0d want=0", cnt[2]); end
    total++; if (empty[2] !== 1'b1)     begin bad++; $display("FAIL post_rst_empty got=%b want=1", empty[2]); end
    total++; if (full[2] !== 1'b0)      begin bad++; $display("FAIL post_rst_full got=%b want=0", full[2]); end
    total++; if (err[2] !== 1'b0)       begin bad++; $display("FAIL post_rst_err got=%b want=0", err[2]); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      op_valid[d] = 1'b0; op[d] = 2'd0; data[d] = '0;
    end
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_enq_deq();
    test_errors();
    test_back_to_back();
    test_min_replace();
    test_random();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
